axis_fifo_tx: RTL

//  - AXI-Stream transmitter on the read side of the accelerator's output fifo (show-ahead, pop-on-ready).
//  - Pops a programmed number of words and drives them onto m_axis with a registered output stage.
//  - Marks the final beat with tlast, then pulses done. Sits between the FIR output fifo and the AXIS master port.

---
 rtl/accel_pkg.sv | 13 +
 rtl/axis_out_reg.sv | 33 +++
 rtl/axis_fifo_tx.sv | 104 ++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared types and default sizes for the accelerator output path.
package accel_pkg;

  localparam int TX_WIDTH    = 32;
  localparam int TX_LEN_BITS = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_STREAM,
    TX_FLUSH
  } tx_state_t;

endpackage : accel_pkg

// File: rtl/axis_out_reg.sv
// AXIS output register slot: one beat of storage, 1-cycle load-to-valid latency.
// A load wins over an ack, so a pop and a handshake in the same cycle keep tvalid high.
module axis_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ack,
  output logic             tvalid,
  output logic [WIDTH-1:0] tdata,
  output logic             tlast
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= load_data;
      tlast  <= load_last;
    end else if (ack) begin
      // tdata deliberately holds its last value after the handshake
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule : axis_out_reg

// File: rtl/axis_fifo_tx.sv
// Pops a programmed number of words from a show-ahead fifo onto AXIS; fifo word to tvalid is 1 cycle.
// Pops only when the output slot is free, so tready low stalls the fifo without loss or duplication.
module axis_fifo_tx
  import accel_pkg::*;
#(
  parameter int WIDTH    = TX_WIDTH,
  parameter int LEN_BITS = TX_LEN_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_BITS-1:0] frame_len,
  input  logic                fifo_empty,
  input  logic [WIDTH-1:0]    fifo_data,
  output logic                fifo_pop,
  output logic                m_axis_tvalid,
  output logic [WIDTH-1:0]    m_axis_tdata,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                busy,
  output logic                done,
  output logic [LEN_BITS-1:0] beat_cnt
);

  tx_state_t           state, state_nxt;
  logic [LEN_BITS-1:0] len;
  logic [LEN_BITS-1:0] issued;
  logic                slot_free;
  logic                last_pop;
  logic                hs;
  logic                accept;
  logic                done_nxt;

  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign hs        = m_axis_tvalid && m_axis_tready;
  assign accept    = (state == TX_IDLE) && start;
  assign busy      = (state != TX_IDLE);

  assign fifo_pop  = (state == TX_STREAM) && !fifo_empty && slot_free && (issued != len);
  assign last_pop  = fifo_pop && (issued == len - LEN_BITS'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TX_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (start) begin
          if (frame_len != '0) state_nxt = TX_STREAM;
          else                 done_nxt  = 1'b1;
        end
      end
      TX_STREAM: begin
        if (last_pop) state_nxt = TX_FLUSH;
      end
      TX_FLUSH: begin
        if (hs && m_axis_tlast) begin
          done_nxt  = 1'b1;
          state_nxt = TX_IDLE;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len      <= '0;
      issued   <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      len      <= frame_len;
      issued   <= '0;
      beat_cnt <= '0;
    end else begin
      if (fifo_pop) issued   <= issued + LEN_BITS'(1);
      if (hs)       beat_cnt <= beat_cnt + LEN_BITS'(1);
    end
  end

  axis_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fifo_pop),
    .load_data (fifo_data),
    .load_last (last_pop),
    .ack       (hs),
    .tvalid    (m_axis_tvalid),
    .tdata     (m_axis_tdata),
    .tlast     (m_axis_tlast)
  );

endmodule : axis_fifo_tx
